// File: rtl/cook_timer.sv
// Microwave cook timer: four-digit BCD MM:SS entry, countdown while the magnetron is on, latched done flag.
// Define COOK_TIMER_PRESCALE_EN to divide clk by CLK_HZ into one-second ticks; otherwise every running cycle is one second.
module cook_timer #(
  parameter int CLK_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clearn,
  input  logic       digit_load,
  input  logic [3:0] digit,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done
);

  typedef enum logic [1:0] {IDLE, SET, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] min_tens_nxt, min_ones_nxt, sec_tens_nxt, sec_ones_nxt;
  logic       timer_done_nxt;
  logic       running, tick, entry;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       dec_zero, entry_zero;

  // SET and RUN always hold a nonzero count, so no separate zero check is needed here.
  assign running = mag_on && (state == SET || state == RUN);
  assign entry   = digit_load && !mag_on && (digit <= 4'd9);

`ifdef COOK_TIMER_PRESCALE_EN
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] presc, presc_nxt;

  assign tick = running && (presc == PW'(CLK_HZ - 1));

  // Prescaler freezes while paused so a partial second survives stop/start.
  always_comb begin
    presc_nxt = presc;
    if (!clearn)      presc_nxt = '0;
    else if (tick)    presc_nxt = '0;
    else if (running) presc_nxt = presc + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) presc <= '0;
    else       presc <= presc_nxt;
  end
`else
  // One clk per second; the parameter only guards against a zero-rate build.
  assign tick = running && (CLK_HZ > 0);
`endif

  // One-second BCD decrement; seconds 60-99 count down as entered.
  always_comb begin
    dec_mt = min_tens;
    dec_mo = min_ones;
    dec_st = sec_tens;
    dec_so = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_so = sec_ones - 4'd1;
    end else if (sec_tens != 4'd0) begin
      dec_st = sec_tens - 4'd1;
      dec_so = 4'd9;
    end else if (min_ones != 4'd0 || min_tens != 4'd0) begin
      dec_st = 4'd5;
      dec_so = 4'd9;
      if (min_ones != 4'd0) begin
        dec_mo = min_ones - 4'd1;
      end else begin
        dec_mt = min_tens - 4'd1;
        dec_mo = 4'd9;
      end
    end
  end

  assign dec_zero   = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);
  assign entry_zero = ({min_ones, sec_tens, sec_ones, digit} == 16'h0000);

  // NOTE: every next-state variable gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    min_tens_nxt   = min_tens;
    min_ones_nxt   = min_ones;
    sec_tens_nxt   = sec_tens;
    sec_ones_nxt   = sec_ones;
    timer_done_nxt = timer_done;
    if (!clearn) begin
      state_nxt      = IDLE;
      min_tens_nxt   = 4'd0;
      min_ones_nxt   = 4'd0;
      sec_tens_nxt   = 4'd0;
      sec_ones_nxt   = 4'd0;
      timer_done_nxt = 1'b0;
    end else if (tick) begin
      min_tens_nxt = dec_mt;
      min_ones_nxt = dec_mo;
      sec_tens_nxt = dec_st;
      sec_ones_nxt = dec_so;
      if (dec_zero) begin
        state_nxt      = DONE;
        timer_done_nxt = 1'b1;
      end else begin
        state_nxt = RUN;
      end
    end else if (entry) begin
      min_tens_nxt   = min_ones;
      min_ones_nxt   = sec_tens;
      sec_tens_nxt   = sec_ones;
      sec_ones_nxt   = digit;
      timer_done_nxt = 1'b0;
      state_nxt      = entry_zero ? IDLE : SET;
    end else begin
      case (state)
        SET:     if (mag_on)  state_nxt = RUN;
        RUN:     if (!mag_on) state_nxt = SET;
        default: state_nxt = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      timer_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      min_tens   <= min_tens_nxt;
      min_ones   <= min_ones_nxt;
      sec_tens   <= sec_tens_nxt;
      sec_ones   <= sec_ones_nxt;
      timer_done <= timer_done_nxt;
    end
  end

endmodule

// File: tb/tb_cook_timer.sv
// Self-checking bench for cook_timer: per-cycle expectations queued at drive time, compared against sampled outputs.
// Builds with or without COOK_TIMER_PRESCALE_EN; with it the DUT runs at CLK_HZ=4.
module tb_cook_timer;

`ifdef COOK_TIMER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic       clk = 1'b0;
  logic       reset, clearn, digit_load, mag_on;
  logic [3:0] digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done;
  logic [15:0] disp;

  typedef struct {
    string       name;
    logic [15:0] disp;
    logic        done;
  } entry_t;

  entry_t exp_q[$];
  entry_t obs_q[$];
  int     errors = 0;
  int     checks = 0;

  cook_timer #(.CLK_HZ(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .clearn     (clearn),
    .digit_load (digit_load),
    .digit      (digit),
    .mag_on     (mag_on),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done)
  );

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the expected result, sample on the following falling edge.
  task automatic step(input logic rs, input logic cn, input logic dl, input logic [3:0] dg,
                      input logic mg, input logic [15:0] ed, input logic edn, input string nm);
    entry_t e, o;
    reset = rs; clearn = cn; digit_load = dl; digit = dg; mag_on = mg;
    e.name = nm; e.disp = ed; e.done = edn;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    o.name = nm; o.disp = disp; o.done = timer_done;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    entry_t e, o;
    step(1, 1, 0, 0, 0, 16'h0000, 0, "reset");
    step(1, 1, 1, 4'd7, 0, 16'h0000, 0, "reset_over_load");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.disp !== e.disp || o.done !== e.done) begin
        errors++;
        $display("FAIL %s: got %h done=%b, want %h done=%b", e.name, o.disp, o.done, e.disp, e.done);
      end
    end
  endtask

  task automatic test_entry();
    entry_t e, o;
    step(0, 1, 1, 4'd1, 0, 16'h0001, 0, "entry_1");
    step(0, 1, 1, 4'd3, 0, 16'h0013, 0, "entry_13");
    step(0, 1, 1, 4'd0, 0, 16'h0130, 0, "entry_130");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 16'h0130, 0, "entry_hold");
    step(0, 1, 1, 4'd10, 0, 16'h0130, 0, "entry_bad_digit");
    step(0, 1, 1, 4'd15, 0, 16'h0130, 0, "entry_bad_digit_f");
    step(0, 0, 1, 4'd4, 0, 16'h0000, 0, "clear_over_load");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.disp !== e.disp || o.done !== e.done) begin
        errors++;
        $display("FAIL %s: got %h done=%b, want %h done=%b", e.name, o.disp, o.done, e.disp, e.done);
      end
    end
  endtask

  task automatic test_countdown();
    entry_t e, o;
    step(0, 0, 0, 0, 0, 16'h0000, 0, "cd_clear");
    step(0, 1, 1, 4'd5, 0, 16'h0005, 0, "cd_load");
    for (int i = 1; i <= 5 * P; i++)
      step(0, 1, 0, 0, 1, 16'(5 - i / P), (i == 5 * P), "cd_run");
    for (int i = 0; i < 2 * P; i++) step(0, 1, 0, 0, 1, 16'h0000, 1, "cd_no_wrap");
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 16'h0000, 1, "cd_done_held");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.disp !== e.disp || o.done !== e.done) begin
        errors++;
        $display("FAIL %s: got %h done=%b, want %h done=%b", e.name, o.disp, o.done, e.disp, e.done);
      end
    end
  endtask

  task automatic test_borrow();
    entry_t e, o;
    step(0, 0, 0, 0, 0, 16'h0000, 0, "bw_clear");
    step(0, 1, 1, 4'd1, 0, 16'h0001, 0, "bw_load");
    step(0, 1, 1, 4'd0, 0, 16'h0010, 0, "bw_load");
    step(0, 1, 1, 4'd0, 0, 16'h0100, 0, "bw_load");
    for (int i = 1; i <= P; i++) step(0, 1, 0, 0, 1, (i == P) ? 16'h0059 : 16'h0100, 0, "bw_min_to_sec");
    step(0, 0, 0, 0, 0, 16'h0000, 0, "bw_clear");
    step(0, 1, 1, 4'd9, 0, 16'h0009, 0, "bw_load");
    step(0, 1, 1, 4'd0, 0, 16'h0090, 0, "bw_load");
    for (int i = 1; i <= P; i++) step(0, 1, 0, 0, 1, (i == P) ? 16'h0089 : 16'h0090, 0, "bw_90s");
    step(0, 0, 0, 0, 0, 16'h0000, 0, "bw_clear");
    step(0, 1, 1, 4'd1, 0, 16'h0001, 0, "bw_load");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 4'd0, 0, 16'h0010 << (4 * i), 0, "bw_load");
    for (int i = 1; i <= P; i++) step(0, 1, 0, 0, 1, (i == P) ? 16'h0959 : 16'h1000, 0, "bw_min_tens");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.disp !== e.disp || o.done !== e.done) begin
        errors++;
        $display("FAIL %s: got %h done=%b, want %h done=%b", e.name, o.disp, o.done, e.disp, e.done);
      end
    end
  endtask

  task automatic test_pause();
    entry_t e, o;
    step(0, 0, 0, 0, 0, 16'h0000, 0, "ps_clear");
`ifdef COOK_TIMER_PRESCALE_EN
    step(0, 1, 1, 4'd2, 0, 16'h0002, 0, "ps_load");
    for (int i = 1; i <= 6; i++) step(0, 1, 0, 0, 1, (i < 4) ? 16'h0002 : 16'h0001, 0, "ps_run");
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 16'h0001, 0, "ps_paused");
    step(0, 1, 0, 0, 1, 16'h0001, 0, "ps_resume_1");
    step(0, 1, 0, 0, 1, 16'h0000, 1, "ps_resume_2");
`else
    step(0, 1, 1, 4'd3, 0, 16'h0003, 0, "ps_load");
    step(0, 1, 0, 0, 1, 16'h0002, 0, "ps_run");
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 16'h0002, 0, "ps_paused");
    step(0, 1, 0, 0, 1, 16'h0001, 0, "ps_resume_1");
    step(0, 1, 0, 0, 1, 16'h0000, 1, "ps_resume_2");
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.disp !== e.disp || o.done !== e.done) begin
        errors++;
        $display("FAIL %s: got %h done=%b, want %h done=%b", e.name, o.disp, o.done, e.disp, e.done);
      end
    end
  endtask

  task automatic test_cancel();
    entry_t e, o;
    step(0, 0, 0, 0, 0, 16'h0000, 0, "cn_clear");
    step(0, 1, 1, 4'd7, 0, 16'h0007, 0, "cn_load");
    step(0, 1, 1, 4'd5, 1, (P == 1) ? 16'h0006 : 16'h0007, 0, "cn_load_ignored");
    for (int i = 1; i < P - 1; i++) step(0, 1, 0, 0, 1, 16'h0007, 0, "cn_run");
    step(0, 0, 0, 0, 1, 16'h0000, 0, "cn_clear_on_tick");
    for (int i = 0; i < P + 1; i++) step(0, 1, 0, 0, 1, 16'h0000, 0, "cn_idle_mag_on");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.disp !== e.disp || o.done !== e.done) begin
        errors++;
        $display("FAIL %s: got %h done=%b, want %h done=%b", e.name, o.disp, o.done, e.disp, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    entry_t e, o;
    step(0, 0, 0, 0, 0, 16'h0000, 0, "bb_clear");
    step(0, 1, 1, 4'd1, 0, 16'h0001, 0, "bb_load");
    for (int i = 1; i <= P; i++) step(0, 1, 0, 0, 1, (i == P) ? 16'h0000 : 16'h0001, (i == P), "bb_expire");
    step(0, 1, 1, 4'd3, 0, 16'h0003, 0, "bb_reload_clears_done");
    step(0, 1, 0, 0, 1, (P == 1) ? 16'h0002 : 16'h0003, 0, "bb_run");
    step(1, 1, 0, 0, 1, 16'h0000, 0, "bb_reset_mid_run");
    step(0, 1, 0, 0, 0, 16'h0000, 0, "bb_after_reset");
    step(0, 1, 1, 4'd8, 0, 16'h0008, 0, "bb_load_after_reset");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.disp !== e.disp || o.done !== e.done) begin
        errors++;
        $display("FAIL %s: got %h done=%b, want %h done=%b", e.name, o.disp, o.done, e.disp, e.done);
      end
    end
  endtask

  initial begin
    reset = 1'b1; clearn = 1'b1; digit_load = 1'b0; digit = 4'd0; mag_on = 1'b0;
    @(negedge clk);
    test_reset();
    test_entry();
    test_countdown();
    test_borrow();
    test_pause();
    test_cancel();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
